// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter that lets several packet producers share
// one SPI TX byte port. A granted requester streams a 41-byte packet into a
// local buffer. The buffer is then replayed to the SPI port without gaps, and
// the arbiter waits out the serialization time before granting again.
module spi_tx_arbiter #(
  parameter int N_REQ     = 3,
  parameter int PKT_BYTES = 41,
  parameter int GAP_DATA  = 330,
  parameter int GAP_INT   = 74
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_byte,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               spi_tx_valid,
  output logic [7:0]         spi_tx_byte,
  output logic               busy
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int GAP_MAX = (GAP_DATA > GAP_INT) ? GAP_DATA : GAP_INT;
  localparam int CNT_W   = $clog2(GAP_MAX + 1);
  localparam logic [5:0] LAST_IDX = 6'(PKT_BYTES - 1);
  localparam logic [5:0] LOAD_END = 6'(PKT_BYTES);

  typedef enum logic [1:0] {IDLE, COLLECT, LOAD, COOLDOWN} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [N_REQ-1:0]   r_grant;
  logic [PTR_W-1:0]   r_ptr;
  logic [5:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_spiValid;
  logic [7:0]         r_spiByte;
  logic               r_busy;
  logic [7:0]         r_buf [PKT_BYTES];

  logic [PTR_W-1:0]   w_sel;
  logic [N_REQ-1:0]   w_selOneHot;
  logic [7:0]         w_reqByte;
  logic               w_accept;

  // Index that lies off positions after base, wrapping around the requesters.
  function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Round-robin pick: first requester after the pointer, scanning upward with wrap.
  always_comb begin
    w_sel = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[wrapIdx(r_ptr, k)]) w_sel = wrapIdx(r_ptr, k);
    end
  end

  assign w_selOneHot = N_REQ'(1) << w_sel;

  // Byte from the granted requester; the pointer always names the current grant.
  always_comb begin
    w_reqByte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_ptr == PTR_W'(i)) w_reqByte = req_byte[8*i +: 8];
    end
  end

  assign req_ready = (r_state == COLLECT) ? r_grant : '0;
  assign w_accept  = |(req_valid & req_ready);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic; LOAD length is fixed because the SPI port cannot stall.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (|req_valid) w_nextState = COLLECT;
      COLLECT:  if (w_accept && (r_idx == LAST_IDX)) w_nextState = LOAD;
      LOAD:     if (r_idx == LOAD_END) w_nextState = COOLDOWN;
      COOLDOWN: if (r_cnt <= CNT_W'(1)) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Grant, pointer, byte index, cooldown counter and registered SPI outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= '0;
      r_ptr      <= PTR_W'(N_REQ - 1);
      r_idx      <= '0;
      r_cnt      <= '0;
      r_spiValid <= 1'b0;
      r_spiByte  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_busy     <= (w_nextState != IDLE);
      r_spiValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_grant <= w_selOneHot;
            r_ptr   <= w_sel;
            r_idx   <= '0;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_grant    <= '0;
              r_idx      <= '0;
              r_spiValid <= 1'b1;
              r_spiByte  <= r_buf[0];
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        LOAD: begin
          if (r_idx == LOAD_END) begin
            r_cnt <= r_buf[0][6] ? CNT_W'(GAP_INT) : CNT_W'(GAP_DATA);
          end else begin
            r_spiByte <= r_buf[r_idx];
            r_idx     <= r_idx + 6'd1;
          end
        end
        COOLDOWN: r_cnt <= r_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Packet buffer; its contents are don't-care until fully written again.
  always_ff @(posedge clk) begin
    if ((r_state == COLLECT) && w_accept) r_buf[r_idx] <= w_reqByte;
  end

  assign grant        = r_grant;
  assign spi_tx_valid = r_spiValid;
  assign spi_tx_byte  = r_spiByte;
  assign busy         = r_busy;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: directed bench for spi_tx_arbiter with behavioural
// requesters, an SPI-side capture monitor and hand-computed timing expectations.
module tb_spi_tx_arbiter;

  localparam int N  = 3;
  localparam int PB = 41;
  localparam int GD = 330;
  localparam int GI = 74;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           spi_tx_valid;
  logic [7:0]     spi_tx_byte;
  logic           busy;

  spi_tx_arbiter #(.N_REQ(N), .PKT_BYTES(PB), .GAP_DATA(GD), .GAP_INT(GI)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_byte(req_byte),
    .req_ready(req_ready), .grant(grant), .spi_tx_valid(spi_tx_valid),
    .spi_tx_byte(spi_tx_byte), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [7:0] pkt [N][PB];
  int pos [N];
  bit active [N];
  int pktsLeft [N];
  bit bubble [N];
  bit phase [N];
  int accepted [N];
  int grantHigh [N];

  int grantOrder [$];
  int pulseCyc [$];
  logic [7:0] cap [4][PB];
  int capIdx;
  bit capturing;
  int capCount;
  int idleCyc;
  int firstGrantCyc;
  int multiReady;
  logic [N-1:0] prevGrant;
  logic prevBusy;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fillPkt(input int r, input logic [7:0] meta, input logic [7:0] xorVal);
    pkt[r][0] = meta;
    for (int k = 1; k < PB; k++) pkt[r][k] = 8'(k) ^ xorVal;
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      pos[i] = 0; active[i] = 0; pktsLeft[i] = 0; bubble[i] = 0; phase[i] = 0;
      accepted[i] = 0; grantHigh[i] = 0;
    end
    grantOrder.delete();
    pulseCyc.delete();
    capIdx = 0; capturing = 0; capCount = 0; idleCyc = -1; firstGrantCyc = -1;
    multiReady = 0; prevGrant = grant; prevBusy = busy;
  endtask

  task automatic startReq(input int r, input int nPkts, input bit withBubbles);
    active[r] = 1; pktsLeft[r] = nPkts; pos[r] = 0; bubble[r] = withBubbles; phase[r] = 0;
  endtask

  // One clock cycle: drive requesters, clock, then observe outputs 1 time unit later.
  task automatic applyStimulus();
    logic [N-1:0] acc;
    logic [N-1:0] rdy;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = active[i] && !(bubble[i] && phase[i]);
      req_byte[8*i +: 8] = active[i] ? pkt[i][pos[i]] : 8'h00;
    end
    #1;
    rdy = req_ready;
    acc = req_valid & req_ready;
    if ($countones(req_ready) > 1) multiReady++;
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        accepted[i]++;
        pos[i]++;
        if (pos[i] == PB) begin
          pos[i] = 0;
          pktsLeft[i]--;
          if (pktsLeft[i] == 0) active[i] = 0;
        end
      end
      if (rdy[i]) phase[i] = !phase[i];
    end
    if ((grant != '0) && (prevGrant == '0)) begin
      for (int i = 0; i < N; i++) if (grant[i]) grantOrder.push_back(i);
      if (firstGrantCyc < 0) firstGrantCyc = cycle;
    end
    for (int i = 0; i < N; i++) if (grant[i]) grantHigh[i]++;
    if (spi_tx_valid) begin
      pulseCyc.push_back(cycle);
      capturing = 1;
      capIdx = 0;
    end else if (capturing) begin
      if (capCount < 4) cap[capCount][capIdx] = spi_tx_byte;
      capIdx++;
      if (capIdx == PB) begin
        capturing = 0;
        capCount++;
      end
    end
    if (prevBusy && !busy) idleCyc = cycle;
    prevGrant = grant;
    prevBusy  = busy;
  endtask

  task automatic runUntilIdle(input string tag, input int maxCyc);
    bit seenBusy;
    bit done;
    bit anyActive;
    seenBusy = 0;
    done = 0;
    for (int n = 0; n < maxCyc && !done; n++) begin
      applyStimulus();
      if (busy) seenBusy = 1;
      anyActive = 0;
      for (int i = 0; i < N; i++) if (active[i]) anyActive = 1;
      if (seenBusy && !busy && !anyActive) done = 1;
    end
    checkOutput({tag, "_reached_idle"}, 32'(done), 32'd1);
  endtask

  task automatic checkCapture(input string tag, input int capSlot, input int r);
    int bad;
    bad = 0;
    if (capSlot < capCount) begin
      for (int k = 0; k < PB; k++) if (cap[capSlot][k] !== pkt[r][k]) bad++;
    end else begin
      bad = PB;
    end
    checkOutput({tag, "_bytes_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_valid"}, 32'(spi_tx_valid), 32'd0);
    checkOutput({tag, "_byte"}, 32'(spi_tx_byte), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Safety net so the bench always ends on its own.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence of scenarios.
  initial begin
    int reqCyc;
    int bound;

    rst = 1'b1;
    req_valid = '0;
    req_byte = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    clearModel();

    // Data packet from requester 0, no bubbles.
    $display("[TB] single data packet");
    fillPkt(0, 8'h3F, 8'h00);
    startReq(0, 1, 0);
    reqCyc = cycle;
    runUntilIdle("data", 600);
    checkOutput("data_grant_latency", 32'(firstGrantCyc - reqCyc), 32'd1);
    checkOutput("data_grant_cycles", 32'(grantHigh[0]), 32'd41);
    checkOutput("data_pulses", 32'(pulseCyc.size()), 32'd1);
    checkCapture("data", 0, 0);
    if (pulseCyc.size() > 0) checkOutput("data_cooldown", 32'(idleCyc - pulseCyc[0]), 32'(42 + GD));
    checkOutput("data_busy_total", 32'(idleCyc - reqCyc), 32'(1 + 41 + 42 + GD));
    checkOutput("data_last_byte_held", 32'(spi_tx_byte), 32'h28);

    // Interest packet: same replay, shorter cooldown.
    $display("[TB] interest packet");
    clearModel();
    fillPkt(0, 8'h48, 8'h80);
    startReq(0, 1, 0);
    reqCyc = cycle;
    runUntilIdle("int", 400);
    checkOutput("int_pulses", 32'(pulseCyc.size()), 32'd1);
    checkCapture("int", 0, 0);
    if (pulseCyc.size() > 0) checkOutput("int_cooldown", 32'(idleCyc - pulseCyc[0]), 32'(42 + GI));
    checkOutput("int_busy_total", 32'(idleCyc - reqCyc), 32'(1 + 41 + 42 + GI));

    // Requester 1 drops valid every other cycle while granted.
    $display("[TB] bubbles");
    clearModel();
    fillPkt(1, 8'h05, 8'hA0);
    startReq(1, 1, 1);
    runUntilIdle("bub", 700);
    checkOutput("bub_grant_cycles", 32'(grantHigh[1]), 32'd81);
    checkOutput("bub_accepted", 32'(accepted[1]), 32'd41);
    if (grantOrder.size() > 0) checkOutput("bub_granted_idx", 32'(grantOrder[0]), 32'd1);
    checkCapture("bub", 0, 1);

    // All requesters hold valid from reset: expected grant order 0,1,2,0.
    $display("[TB] round robin");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
    for (int i = 0; i < N; i++) fillPkt(i, 8'(8'h40 | i), 8'(i << 6));
    startReq(0, 2, 0);
    startReq(1, 1, 0);
    startReq(2, 1, 0);
    runUntilIdle("rr", 900);
    checkOutput("rr_grants", 32'(grantOrder.size()), 32'd4);
    if (grantOrder.size() >= 4) begin
      checkOutput("rr_grant0", 32'(grantOrder[0]), 32'd0);
      checkOutput("rr_grant1", 32'(grantOrder[1]), 32'd1);
      checkOutput("rr_grant2", 32'(grantOrder[2]), 32'd2);
      checkOutput("rr_grant3", 32'(grantOrder[3]), 32'd0);
    end
    checkOutput("rr_pulses", 32'(pulseCyc.size()), 32'd4);
    if (pulseCyc.size() >= 4) begin
      for (int j = 1; j < 4; j++) checkOutput("rr_pulse_gap", 32'(pulseCyc[j] - pulseCyc[j-1]), 32'd158);
    end
    checkCapture("rr_p0", 0, 0);
    checkCapture("rr_p1", 1, 1);
    checkCapture("rr_p2", 2, 2);
    checkCapture("rr_p3", 3, 0);
    checkOutput("rr_multi_ready", 32'(multiReady), 32'd0);
    checkOutput("rr_acc0", 32'(accepted[0]), 32'd82);
    checkOutput("rr_acc1", 32'(accepted[1]), 32'd41);
    checkOutput("rr_acc2", 32'(accepted[2]), 32'd41);

    // Asynchronous reset in the middle of LOAD, then fresh arbitration.
    $display("[TB] reset mid-load");
    clearModel();
    fillPkt(1, 8'h11, 8'h55);
    startReq(1, 1, 0);
    bound = 0;
    while (pulseCyc.size() == 0 && bound < 100) begin
      applyStimulus();
      bound++;
    end
    checkOutput("rml_pulse_seen", 32'(pulseCyc.size()), 32'd1);
    repeat (20) applyStimulus();
    checkOutput("rml_load_byte20", 32'(spi_tx_byte), 32'(pkt[1][19]));
    #2;
    rst = 1'b1;
    #1;
    checkIdleOutputs("rml_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
    for (int i = 0; i < N; i++) fillPkt(i, 8'(8'h20 | i), 8'(i << 6));
    startReq(0, 1, 0);
    startReq(1, 1, 0);
    startReq(2, 1, 0);
    bound = 0;
    while (grantOrder.size() == 0 && bound < 10) begin
      applyStimulus();
      bound++;
    end
    checkOutput("rml_regrant_count", 32'(grantOrder.size()), 32'd1);
    if (grantOrder.size() > 0) checkOutput("rml_regrant_idx", 32'(grantOrder[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
